// File: rtl/up_counter_ctrl_if.sv
// ---------------------------------------------------------------------------
// up_counter_ctrl_if
//   Groups the control, observation and status signals exchanged between
//   the up-counter sequencing controller and its environment.
//
//   master modport (environment side):
//     drives   Start, Stop, Pause, Periodic, Target, Wraps, Count
//     observes CntEn, CntClr, Busy, Done, WrapCnt
//   slave modport (controller side): the mirror image.
// ---------------------------------------------------------------------------
interface up_counter_ctrl_if #(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 4
);
  logic              Start;
  logic              Stop;
  logic              Pause;
  logic              Periodic;
  logic [WIDTH-1:0]  Target;
  logic [WRAP_W-1:0] Wraps;
  logic [WIDTH-1:0]  Count;
  logic              CntEn;
  logic              CntClr;
  logic              Busy;
  logic              Done;
  logic [WRAP_W-1:0] WrapCnt;

  modport master (
    output Start, Stop, Pause, Periodic, Target, Wraps, Count,
    input  CntEn, CntClr, Busy, Done, WrapCnt
  );

  modport slave (
    input  Start, Stop, Pause, Periodic, Target, Wraps, Count,
    output CntEn, CntClr, Busy, Done, WrapCnt
  );
endinterface

// File: rtl/up_counter_ctrl.sv
// ---------------------------------------------------------------------------
// up_counter_ctrl
//   Sequencing controller for an external WIDTH-bit up-counter. Clears the
//   counter, enables it for Wraps*2^WIDTH + Target increments, then stops
//   it and pulses Done. Supports one-shot / periodic runs, pause and abort.
//
//   Ports:
//     Clk  - rising-edge clock
//     Rst  - asynchronous active-low reset
//     bus  - up_counter_ctrl_if.slave:
//              in : Start, Stop, Pause, Periodic, Target, Wraps, Count
//              out: CntEn (Mealy in RUN), CntClr, Busy, Done, WrapCnt
// ---------------------------------------------------------------------------
module up_counter_ctrl #(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  up_counter_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_e            state_q,    state_d;
  logic [WIDTH-1:0]  target_q,   target_d;
  logic [WRAP_W-1:0] wraps_q,    wraps_d;
  logic              periodic_q, periodic_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

  logic term;
  logic cnt_en;
  logic cnt_clr;
  logic busy;
  logic done;

  // Terminal condition: the programmed number of wraps has been completed
  // and the counter sits on the final value. Pause does not mask it.
  assign term = (state_q == S_RUN) &&
                (wrap_cnt_q == wraps_q) &&
                (bus.Count == target_q);

  // State register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      wraps_q    <= '0;
      periodic_q <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      wraps_q    <= wraps_d;
      periodic_q <= periodic_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  // Next-state logic, including run-parameter latching and wrap tracking
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    wraps_d    = wraps_q;
    periodic_d = periodic_q;
    wrap_cnt_d = wrap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.Start && !bus.Stop) begin
          target_d   = bus.Target;
          wraps_d    = bus.Wraps;
          periodic_d = bus.Periodic;
          state_d    = S_CLEAR;
        end
      end
      S_CLEAR: begin
        wrap_cnt_d = '0;
        state_d    = bus.Stop ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        // A wrap is the enabled edge that takes the counter from max to 0.
        if (cnt_en && (bus.Count == CNT_MAX)) begin
          wrap_cnt_d = wrap_cnt_q + 1'b1;
        end
        if (bus.Stop) begin
          state_d = S_IDLE;
        end else if (term) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Stop in DONE lets the pulse through but suppresses the restart.
        state_d = (bus.Stop || !periodic_q) ? S_IDLE : S_CLEAR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic; CntEn reacts combinationally to Pause/Stop/term in RUN
  always_comb begin
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      S_IDLE:  busy    = 1'b0;
      S_CLEAR: cnt_clr = 1'b1;
      S_RUN:   cnt_en  = !bus.Pause && !term && !bus.Stop;
      S_DONE:  done    = 1'b1;
      default: busy    = 1'b0;
    endcase
  end

  assign bus.CntEn   = cnt_en;
  assign bus.CntClr  = cnt_clr;
  assign bus.Busy    = busy;
  assign bus.Done    = done;
  assign bus.WrapCnt = wrap_cnt_q;

endmodule

// File: tb/tb_up_counter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_up_counter_ctrl
//   Self-checking bench for up_counter_ctrl. A behavioural up-counter closes
//   the loop on CntEn/CntClr -> Count. Cycle k means the clock period that
//   follows the k-th rising edge after the edge that sampled Start (edge 0).
// ---------------------------------------------------------------------------
module tb_up_counter_ctrl;

  localparam int WIDTH  = 3;
  localparam int WRAP_W = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  up_counter_ctrl_if #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) bus ();

  up_counter_ctrl #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) dut (
    .Clk (clk),
    .Rst (rst_n),
    .bus (bus)
  );

  // External counter datapath: not reset by the controller's reset
  logic [WIDTH-1:0] cnt_model = '0;
  always_ff @(posedge clk) begin
    if (bus.CntClr)     cnt_model <= '0;
    else if (bus.CntEn) cnt_model <= cnt_model + 1'b1;
  end
  assign bus.Count = cnt_model;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to the next cycle; inputs are driven 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive a launch in IDLE; returns settled in cycle 1
  task automatic start_run(input logic [WIDTH-1:0] tgt, input logic [WRAP_W-1:0] wr,
                           input logic per);
    bus.Start    = 1'b1;
    bus.Target   = tgt;
    bus.Wraps    = wr;
    bus.Periodic = per;
    cyc = -1;
    tick();             // edge 0 samples Start
    cyc = 1;
    bus.Start = 1'b0;
    #1;
  endtask

  // Walk cycles until Done is seen (bounded); counts enabled cycles on the way
  task automatic wait_done(input int limit, output int dc, output int en_cnt);
    dc = -1;
    en_cnt = 0;
    for (int i = 0; i < limit; i++) begin
      if (bus.Done === 1'b1) begin
        dc = cyc;
        break;
      end
      if (bus.CntEn === 1'b1) en_cnt++;
      tick();
      #1;
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0]  target;
    logic [WRAP_W-1:0] wraps;
    int                n_inc;
    int                done_cyc;
    logic [WIDTH-1:0]  cnt_at_done;
    logic [WRAP_W-1:0] wrap_at_done;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int dc;
    int en;
    bit saw_done;

    // Hand-computed: N = Wraps*8 + Target, Done in cycle 3+N
    vecs[0] = '{3'd5, 4'd1, 13, 16, 3'd5, 4'd1};
    vecs[1] = '{3'd0, 4'd0,  0,  3, 3'd0, 4'd0};
    vecs[2] = '{3'd3, 4'd0,  3,  6, 3'd3, 4'd0};
    vecs[3] = '{3'd7, 4'd0,  7, 10, 3'd7, 4'd0};
    vecs[4] = '{3'd0, 4'd1,  8, 11, 3'd0, 4'd1};
    vecs[5] = '{3'd7, 4'd1, 15, 18, 3'd7, 4'd1};
    vecs[6] = '{3'd2, 4'd2, 18, 21, 3'd2, 4'd2};

    bus.Start = 1'b0; bus.Stop = 1'b0; bus.Pause = 1'b0; bus.Periodic = 1'b0;
    bus.Target = '0;  bus.Wraps = '0;
    rst_n = 1'b0;
    #12;
    check("rst_cnten",   32'(bus.CntEn),   0);
    check("rst_cntclr",  32'(bus.CntClr),  0);
    check("rst_busy",    32'(bus.Busy),    0);
    check("rst_done",    32'(bus.Done),    0);
    check("rst_wrapcnt", 32'(bus.WrapCnt), 0);
    rst_n = 1'b1;
    tick();
    tick();

    // ---- one-shot table ----
    foreach (vecs[i]) begin
      start_run(vecs[i].target, vecs[i].wraps, 1'b0);
      check($sformatf("v%0d_clr_c1", i),  32'(bus.CntClr), 1);
      check($sformatf("v%0d_busy_c1", i), 32'(bus.Busy),   1);
      check($sformatf("v%0d_en_c1", i),   32'(bus.CntEn),  0);
      tick(); #1;
      check($sformatf("v%0d_count_c2", i), 32'(bus.Count), 0);
      wait_done(60, dc, en);
      check($sformatf("v%0d_done_cyc", i),  32'(dc), 32'(vecs[i].done_cyc));
      check($sformatf("v%0d_en_cycles", i), 32'(en), 32'(vecs[i].n_inc));
      check($sformatf("v%0d_count", i),     32'(bus.Count),   32'(vecs[i].cnt_at_done));
      check($sformatf("v%0d_wrapcnt", i),   32'(bus.WrapCnt), 32'(vecs[i].wrap_at_done));
      check($sformatf("v%0d_en_done", i),   32'(bus.CntEn),   0);
      tick(); #1;
      check($sformatf("v%0d_busy_fall", i), 32'(bus.Busy),    0);
      check($sformatf("v%0d_done_low", i),  32'(bus.Done),    0);
      check($sformatf("v%0d_wrap_hold", i), 32'(bus.WrapCnt), 32'(vecs[i].wrap_at_done));
      $display("vec %0d: target=%0d wraps=%0d done_cyc=%0d count=%0d wrapcnt=%0d",
               i, vecs[i].target, vecs[i].wraps, dc, bus.Count, bus.WrapCnt);
      tick();
    end

    // ---- reset in IDLE clears a nonzero WrapCnt ----
    rst_n = 1'b0; #1;
    check("idle_rst_wrapcnt", 32'(bus.WrapCnt), 0);
    tick(); rst_n = 1'b1; tick();

    // ---- reset mid-run ----
    start_run(3'd5, 4'd1, 1'b0);
    for (int k = 0; k < 5; k++) begin tick(); end
    #1;
    check("mrst_count_c6", 32'(bus.Count), 4);
    check("mrst_en_c6",    32'(bus.CntEn), 1);
    rst_n = 1'b0; #1;
    check("mrst_en",      32'(bus.CntEn),   0);
    check("mrst_busy",    32'(bus.Busy),    0);
    check("mrst_wrapcnt", 32'(bus.WrapCnt), 0);
    tick(); rst_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick(); #1;
      if (bus.Done === 1'b1 || bus.Busy === 1'b1) saw_done = 1'b1;
    end
    check("mrst_idle_quiet", 32'(saw_done), 0);
    check("mrst_count_kept", 32'(bus.Count), 4);
    $display("reset mid-run: count=%0d busy=%0d", bus.Count, bus.Busy);

    // ---- pause: cycles 3..6 ----
    start_run(3'd3, 4'd0, 1'b0);
    tick();                                 // cycle 2
    for (int k = 3; k <= 6; k++) begin
      tick();
      bus.Pause = 1'b1;
      #1;
      check($sformatf("pause_count_c%0d", k), 32'(bus.Count), 1);
      check($sformatf("pause_en_c%0d", k),    32'(bus.CntEn), 0);
    end
    tick();
    bus.Pause = 1'b0;
    #1;
    wait_done(40, dc, en);
    check("pause_done_cyc", 32'(dc), 10);
    check("pause_count",    32'(bus.Count), 3);
    $display("pause: done_cyc=%0d count=%0d", dc, bus.Count);
    tick(); tick();

    // ---- periodic, with inputs changed mid-run ----
    start_run(3'd2, 4'd0, 1'b1);
    tick();
    bus.Target = 3'd6;
    bus.Periodic = 1'b0;
    #1;
    for (int r = 0; r < 3; r++) begin
      wait_done(20, dc, en);
      check($sformatf("per%0d_done_cyc", r), 32'(dc), 32'(5 + 5 * r));
      check($sformatf("per%0d_count", r),    32'(bus.Count), 2);
      $display("periodic run %0d: done_cyc=%0d count=%0d", r, dc, bus.Count);
      if (r < 2) begin
        tick(); #1;
        check($sformatf("per%0d_reclear", r), 32'(bus.CntClr), 1);
        check($sformatf("per%0d_busy", r),     32'(bus.Busy),   1);
      end
    end
    // Stop coincident with DONE: pulse stays, restart is suppressed
    bus.Stop = 1'b1;
    #1;
    check("per_stop_done", 32'(bus.Done), 1);
    tick();
    bus.Stop = 1'b0;
    #1;
    check("per_stop_busy", 32'(bus.Busy),   0);
    check("per_stop_clr",  32'(bus.CntClr), 0);
    tick();

    // ---- abort in cycle 9 with coincident Start ----
    start_run(3'd7, 4'd2, 1'b0);
    for (int k = 0; k < 8; k++) begin tick(); end
    bus.Stop  = 1'b1;
    bus.Start = 1'b1;
    #1;
    check("abort_count_c9", 32'(bus.Count), 7);
    check("abort_en_c9",    32'(bus.CntEn), 0);
    check("abort_busy_c9",  32'(bus.Busy),  1);
    tick();
    bus.Stop  = 1'b0;
    bus.Start = 1'b0;
    #1;
    check("abort_busy_c10",  32'(bus.Busy),   0);
    check("abort_clr_c10",   32'(bus.CntClr), 0);
    check("abort_count_c10", 32'(bus.Count),  7);
    saw_done = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick(); #1;
      if (bus.Done === 1'b1 || bus.Busy === 1'b1) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 0);
    $display("abort: busy=%0d count=%0d wrapcnt=%0d", bus.Busy, bus.Count, bus.WrapCnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/up_counter_ctrl.md
# up_counter_ctrl

Sequencing controller for the lab's WIDTH-bit up-counter datapath. It clears the counter, enables it for a programmed number of increments (whole wraps plus a final count), then stops it and reports completion. It supports one-shot and periodic (auto-restart) modes, pause, and abort. It sits between the top-level control inputs and an external up_counter instance: it drives that instance's enable and clear, and observes its Count output.

## Interface
Parameters:
- WIDTH, 3, width of the controlled counter's Count
- WRAP_W, 4, width of the wrap-count field and internal wrap counter

Ports:
- Clk  in  1  system clock, rising-edge
- Rst  in  1  asynchronous, active-low reset
- Start  in  1  level; sampled only in IDLE; launches a run
- Stop  in  1  level; aborts any active run; highest priority
- Pause  in  1  level; freezes counting while in RUN
- Periodic  in  1  latched at Start; 1 = auto-restart after each Done
- Target  in  WIDTH  final count value, latched at Start
- Wraps  in  WRAP_W  number of full counter wraps before Target, latched at Start
- Count  in  WIDTH  observed counter value from the datapath
- CntEn  out  1  counter enable (to counter En)
- CntClr  out  1  counter clear (to counter reset input, active-high)
- Busy  out  1  high in any state except IDLE
- Done  out  1  one-cycle completion pulse
- WrapCnt  out  WRAP_W  wraps completed in the current run

## Operation
- States: IDLE, CLEAR, RUN, DONE.
- Datapath contract: the counter increments on each rising edge where CntEn=1. The counter reads 0 in the cycle after CntClr=1. It wraps from 2^WIDTH-1 to 0.
- IDLE: CntEn=0, CntClr=0, Busy=0, WrapCnt holds its last value. If Start=1 and Stop=0, latch Target, Wraps and Periodic, then go to CLEAR.
- CLEAR (1 cycle): CntClr=1, CntEn=0, internal wrap counter cleared to 0, then go to RUN.
- RUN:
  - term = (WrapCnt == Wraps_latched) && (Count == Target_latched).
  - CntEn = !Pause && !term && !Stop. This is combinational (Mealy).
  - WrapCnt increments on an edge where CntEn=1 and Count == 2^WIDTH-1.
  - If term=1 and Stop=0, go to DONE. Pause does not block term detection.
- DONE (1 cycle): Done=1, CntEn=0. Go to CLEAR if Periodic_latched=1, otherwise go to IDLE.
- Stop=1 in CLEAR, RUN or DONE: go to IDLE on the next edge, with CntEn=0 that cycle. No Done is issued, even if term is coincident. In DONE with Stop=1, Done still pulses that cycle, but no restart follows.
- Input changes after Start is latched have no effect on the run in progress. In periodic mode, the next restart reuses the latched values; Start is ignored while Busy=1.
- Count of enabled increments per run: N = Wraps·2^WIDTH + Target. With Wraps=0 and Target=0, N=0: term is true on the first RUN cycle.
- WrapCnt saturation is not needed, because term fires before WrapCnt can exceed Wraps.
- Reset (asynchronous, any time including mid-run): state=IDLE, CntEn=0, CntClr=0, Busy=0, Done=0, WrapCnt=0, all latched fields=0.

## Timing
- Start sampled on edge 0 → CLEAR in cycle 1 (CntClr=1) → RUN from cycle 2 with Count=0.
- Without pause, term is true in cycle 2+N and Done is high in cycle 3+N.
- Each Pause cycle in RUN delays Done by exactly one cycle.
- Periodic period: N+3 cycles from one Done to the next (DONE → CLEAR → RUN).
- Busy rises in cycle 1. In one-shot mode Busy falls in cycle 4+N; in periodic mode it stays high.
- Stop asserted in cycle k → CntEn=0 in cycle k → IDLE in cycle k+1.
- All registered outputs change only on a rising Clk, except under asynchronous reset.

## Test plan
- Reset mid-run: Start, Target=5, Wraps=1; assert Rst=0 in cycle 6 → CntEn, Busy and WrapCnt are 0 immediately. After release, the block idles, Count is untouched, and there is no Done.
- One-shot, WIDTH=3: Target=5, Wraps=1 → N=13, Done pulses in cycle 16, Count=5, WrapCnt=1, Busy falls in cycle 17.
- Zero run: Target=0, Wraps=0 → CntEn never asserts, Done is in cycle 3, Count=0.
- Pause: Target=3, Wraps=0, Pause high for 4 cycles starting in cycle 3 → Done moves from cycle 6 to cycle 10, and Count holds during the pause.
- Periodic: Target=2, Wraps=0, Periodic=1 → Done in cycles 5, 10, 15…, each run re-clears Count. Changing Target mid-run has no effect.
- Abort: Target=7, Wraps=2, Stop in cycle 9 → CntEn=0 in cycle 9, IDLE in cycle 10, no Done. Start in the same cycle as Stop is ignored.
